// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizing for the square-root arbiter.
package sqrt_arb_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned W_DEF       = 16;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        CLEAR
    } state_t;

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1 (mod N)
// and returns the first requesting index as one-hot and binary.
module rr_pick
    import sqrt_arb_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    // First requester found after ptr wins; later candidates are masked by valid.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k + 32'd1) % N);
            if (!valid && req[cand]) begin
                onehot[cand] = 1'b1;
                idx          = cand;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one square-root unit among N requesters with round-robin
// arbitration, a done timeout and a reset pulse to the unit after each job.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   operand_i,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     ack,
    output logic [W/2-1:0]   result_o,
    output logic             err,
    output logic             busy,
    output logic             sq_init,
    output logic [W-1:0]     sq_operand,
    output logic             sq_rst,
    input  logic             sq_done,
    input  logic [W/2-1:0]   sq_result
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          sq_rst_q;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [W-1:0]  op_sel;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // The unit is held in reset by the global reset as well as the CLEAR pulse.
    assign sq_rst = rst | sq_rst_q;

    // Select the winner's operand slice.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) op_sel = operand_i[i*W +: W];
        end
    end

    // Control FSM; every output is set on entry to the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(N - 1);
            cnt        <= '0;
            grant      <= '0;
            ack        <= '0;
            result_o   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            sq_init    <= 1'b0;
            sq_operand <= '0;
            sq_rst_q   <= 1'b0;
        end else begin
            ack      <= '0;
            err      <= 1'b0;
            sq_init  <= 1'b0;
            sq_rst_q <= 1'b0;
            result_o <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick_onehot;
                        ptr        <= pick_idx;
                        sq_operand <= op_sel;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    sq_init <= 1'b1;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (sq_done) begin
                        ack      <= grant;
                        result_o <= sq_result;
                        state    <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        grant    <= '0;
                        sq_rst_q <= 1'b1;
                        state    <= CLEAR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    grant    <= '0;
                    sq_rst_q <= 1'b1;
                    state    <= CLEAR;
                end
                CLEAR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter with a 10-cycle square-root unit model.
module tb_sqrt_arbiter;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 10;
    localparam int RW      = W / 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  operand_i = '0;
    logic [N-1:0]    grant, ack;
    logic [RW-1:0]   result_o;
    logic            err, busy, sq_init, sq_rst;
    logic [W-1:0]    sq_operand;
    logic            sq_done = 1'b0;
    logic [RW-1:0]   sq_result = '0;

    logic hang = 1'b0;
    int   lat = 0;
    int   checks = 0;
    int   errors = 0;
    int   mptr = N - 1;

    sqrt_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .operand_i  (operand_i),
        .grant      (grant),
        .ack        (ack),
        .result_o   (result_o),
        .err        (err),
        .busy       (busy),
        .sq_init    (sq_init),
        .sq_operand (sq_operand),
        .sq_rst     (sq_rst),
        .sq_done    (sq_done),
        .sq_result  (sq_result)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Square-root unit model: done after LAT cycles, latched until sq_rst.
    always @(posedge clk) begin
        if (sq_rst) begin
            sq_done <= 1'b0;
            lat     <= 0;
        end else if (sq_init) begin
            lat <= LAT - 1;
        end else if (lat == 1) begin
            lat <= 0;
            if (!hang) begin
                sq_done   <= 1'b1;
                sq_result <= RW'(isqrt(int'(sq_operand)));
            end
        end else if (lat > 0) begin
            lat <= lat - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int v);
        operand_i[i*W +: W] = W'(v);
    endtask

    function automatic logic [W-1:0] get_op(input int i);
        return operand_i[i*W +: W];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_sq_init", 64'(sq_init), 64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        check("rst_operand", 64'(sq_operand), 64'(0));
        check("rst_sq_rst", 64'(sq_rst), 64'(1));
        rst  = 1'b0;
        mptr = N - 1;
        tick();
        check("post_rst_sq_rst", 64'(sq_rst), 64'(0));
    endtask

    // One arbitrated job from grant to return to idle.
    task automatic serve(input int idx, input int exp_res, input bit exp_err, input bit drop,
                         input bit mid_en, input logic [N-1:0] mid_req);
        int n;
        int inits;
        n = 0;
        while (grant == '0 && n < 40) begin
            tick();
            n++;
        end
        check("grant", 64'(grant), 64'(1 << idx));
        check("busy_on", 64'(busy), 64'(1));
        check("sq_operand", 64'(sq_operand), 64'(get_op(idx)));
        if (mid_en) begin
            req = mid_req;
            set_op(idx, $urandom_range(0, 65535));
        end
        n = 0;
        inits = 0;
        do begin
            tick();
            n++;
            inits += int'(sq_init);
            check("exclusive", 64'((int'(ack != '0) + int'(err) + int'(sq_init)) <= 1), 64'(1));
        end while (ack == '0 && !err && n < TIMEOUT + 40);
        check("sq_init_count", 64'(inits), 64'(1));
        if (exp_err) begin
            check("err", 64'(err), 64'(1));
            check("no_ack", 64'(ack), 64'(0));
            check("err_latency", 64'(n), 64'(TIMEOUT + 1));
            check("err_sq_rst", 64'(sq_rst), 64'(1));
            check("err_grant_clr", 64'(grant), 64'(0));
        end else begin
            check("ack", 64'(ack), 64'(1 << idx));
            check("result", 64'(result_o), 64'(exp_res));
            check("ack_latency", 64'(n), 64'(LAT + 2));
            check("grant_hold", 64'(grant), 64'(1 << idx));
            check("no_err", 64'(err), 64'(0));
            if (drop) req[idx] = 1'b0;
            tick();
            check("ack_pulse", 64'(ack), 64'(0));
            check("clear_sq_rst", 64'(sq_rst), 64'(1));
            check("grant_clr", 64'(grant), 64'(0));
        end
        tick();
        check("busy_off", 64'(busy), 64'(0));
        check("sq_rst_off", 64'(sq_rst), 64'(0));
        check("err_off", 64'(err), 64'(0));
        mptr = idx;
    endtask

    initial begin
        logic [N-1:0] nb;
        logic [N-1:0] midr;
        int w;
        int er;
        int n;

        do_reset();

        // Single requester, 144 -> 12
        set_op(1, 144);
        req = 4'b0010;
        serve(1, 12, 1'b0, 1'b1, 1'b0, '0);

        // All four after reset: grants 0,1,2,3 in order
        do_reset();
        set_op(0, 0);
        set_op(1, 1);
        set_op(2, 81);
        set_op(3, 65535);
        req = 4'b1111;
        serve(0, 0, 1'b0, 1'b1, 1'b0, '0);
        serve(1, 1, 1'b0, 1'b1, 1'b0, '0);
        serve(2, 9, 1'b0, 1'b1, 1'b0, '0);
        serve(3, 255, 1'b0, 1'b1, 1'b0, '0);

        // Unit never finishes: timeout abort, then the held request is regranted
        set_op(2, 400);
        hang = 1'b1;
        req  = 4'b0100;
        serve(2, 0, 1'b1, 1'b0, 1'b0, '0);
        hang = 1'b0;
        serve(2, 20, 1'b0, 1'b1, 1'b0, '0);

        // Reset three cycles into WAIT
        set_op(3, 625);
        set_op(2, 9);
        req = 4'b1100;
        n = 0;
        while (grant == '0 && n < 40) begin
            tick();
            n++;
        end
        check("pre_rst_grant", 64'(grant), 64'(4'b1000));
        repeat (4) tick();
        check("in_wait_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_sq_rst_comb", 64'(sq_rst), 64'(1));
        tick();
        check("abort_grant", 64'(grant), 64'(0));
        check("abort_ack", 64'(ack), 64'(0));
        check("abort_err", 64'(err), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_sq_init", 64'(sq_init), 64'(0));
        check("abort_operand", 64'(sq_operand), 64'(0));
        check("abort_result", 64'(result_o), 64'(0));
        check("abort_sq_rst", 64'(sq_rst), 64'(1));
        tick();
        rst  = 1'b0;
        mptr = N - 1;
        set_op(0, 49);
        req = 4'b1001;
        serve(0, 7, 1'b0, 1'b1, 1'b0, '0);
        serve(3, 25, 1'b0, 1'b1, 1'b0, '0);

        // Owner drops its request mid-job while requester 0 raises its own
        set_op(3, 10000);
        set_op(0, 36);
        req = 4'b1000;
        serve(3, 100, 1'b0, 1'b1, 1'b1, 4'b0001);
        serve(0, 6, 1'b0, 1'b1, 1'b0, '0);

        // Random traffic against the round-robin reference
        for (int t = 0; t < 24; t++) begin
            if (req == '0) begin
                nb = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++) if (nb[i]) set_op(i, $urandom_range(0, 65535));
                req = req | nb;
            end
            w  = rr_winner(req, mptr);
            er = isqrt(int'(get_op(w)));
            nb = N'($urandom_range(0, (1 << N) - 1)) & ~req;
            for (int i = 0; i < N; i++) if (nb[i]) set_op(i, $urandom_range(0, 65535));
            midr = req | nb;
            if ($urandom_range(0, 1) == 1) midr[w] = 1'b0;
            serve(w, er, 1'b0, 1'b1, 1'b1, midr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter N, 4, number of requesters sharing one square-root unit.
REQ-002 Parameter W, 16, operand width; result width is W/2.
REQ-003 Parameter TIMEOUT, 64, maximum cycles to wait for sq_done before abort.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-requester request level, held until ack.
REQ-007 operand_i  input  N*W  packed operands; slice i belongs to requester i.
REQ-008 grant  output  N  one-hot owner of the unit, zero when idle.
REQ-009 ack  output  N  one-cycle completion pulse to the owner.
REQ-010 result_o  output  W/2  root, valid only in the ack cycle.
REQ-011 err  output  1  one-cycle pulse on timeout abort; ack is not pulsed.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 sq_init  output  1  start pulse to the sqrt unit.
REQ-014 sq_operand  output  W  operand latched at grant.
REQ-015 sq_rst  output  1  reset to the sqrt unit.
REQ-016 sq_done  input  1  sqrt unit finished; it stays high until sq_rst.
REQ-017 sq_result  input  W/2  sqrt unit result.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, CLEAR.
REQ-019 IDLE: if any req bit is high, pick the winner round-robin, register the one-hot grant and sq_operand, and go to ISSUE; otherwise stay.
REQ-020 Round-robin: search starts at index ptr+1 mod N; ptr updates to the winner index on grant; reset ptr = N-1, so requester 0 has first priority.
REQ-021 ISSUE: sq_init=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-022 WAIT: on sq_done=1 capture sq_result and go to RESP; else increment counter; when counter reaches TIMEOUT-1 without done, go to CLEAR with err=1 that cycle.
REQ-023 RESP: ack[owner]=1 and result_o=captured root for one cycle, then CLEAR.
REQ-024 CLEAR: sq_rst=1 for one cycle, grant cleared, then IDLE.
REQ-025 sq_rst SHALL also be high whenever rst is high.
REQ-026 Latency: req sampled in IDLE -> sq_init two edges later; sq_done -> ack next cycle; minimum grant-to-grant spacing is 5 cycles plus sqrt latency.
REQ-027 A req deasserted after grant SHALL NOT abort the operation; ack is still pulsed.
REQ-028 req changes outside IDLE SHALL be ignored; operand_i is sampled only at grant.
REQ-029 sq_done high in IDLE or ISSUE (stale) SHALL be ignored.
REQ-030 All outputs except sq_rst SHALL be registered; ack, err and sq_init are never high in the same cycle.

Reset
REQ-031 On rst: state=IDLE, ptr=N-1, counter=0; grant, ack, err, sq_init, busy, result_o and sq_operand are 0.
REQ-032 rst in any state, including WAIT, SHALL abandon the operation without ack or err.

Structure
REQ-033 Package sqrt_arb_pkg SHALL hold the state enum and default N, W, TIMEOUT constants.
REQ-034 Sub-module rr_pick SHALL implement the combinational round-robin picker (req, ptr -> one-hot, index, valid).

Verification
REQ-035 Bench SHALL model the sqrt unit with a 10-cycle latency and a latch-until-reset done.
REQ-036 req=4'b0010, operand 144 -> grant=4'b0010, one sq_init, ack[1] with result_o=12, then sq_rst pulse, busy low.
REQ-037 req=4'b1111 after reset, operands 0/1/81/65535 -> grants in order 0,1,2,3; results 0,1,9,255.
REQ-038 Model never raises done, req[2]=1 -> err pulse after 64 WAIT cycles, no ack, sq_rst pulse, then req[2] is regranted.
REQ-039 rst asserted 3 cycles into WAIT -> all outputs 0 next edge, sq_rst high during rst, next grant goes to requester 0.
REQ-040 req[3] dropped in WAIT while req[0] stays high -> ack[3] still pulses, then requester 0 is granted.
